// File: rtl/voting_pkg.sv
// Shared voting definitions: default sizes, collector states,
// and the slot-slice helper used by the collector and voting.
package voting_pkg;

  localparam int N_DEF = 3;
  localparam int M_DEF = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

  // Slot i occupies bits [(i+1)*n-1 : i*n] of the flat bus
  function automatic int slot_lsb(int i, int n);
    return i * n;
  endfunction

endpackage

// File: rtl/ballot_collector_if.sv
// Ballot intake handshake and result bus of the collector.
interface ballot_collector_if #(
  parameter int N = 3,
  parameter int M = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [M-1:0]       in_id;
  logic [N-1:0]       in_vote;
  logic               close;
  logic [(2**M)*N-1:0] vote;
  logic               vote_valid;
  logic               vote_ack;
  logic [M:0]         count;
  logic               dup_err;

  modport master (
    output in_valid, in_id, in_vote,
    output close, vote_ack,
    input  in_ready, vote, vote_valid,
    input  count, dup_err
  );

  modport slave (
    input  in_valid, in_id, in_vote,
    input  close, vote_ack,
    output in_ready, vote, vote_valid,
    output count, dup_err
  );

endinterface

// File: rtl/ballot_slot.sv
// One voter slot: N-bit ballot plus its cast flag.
module ballot_slot #(
  parameter int          N    = 3,
  parameter logic [N-1:0] FILL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic         clr,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] slot,
  output logic         cast
);

  logic [N-1:0] slot_q, slot_d;
  logic         cast_q, cast_d;

  always_comb begin
    slot_d = slot_q;
    cast_d = cast_q;
    if (clr) begin
      slot_d = FILL;
      cast_d = 1'b0;
    end else if (wr) begin
      slot_d = wdata;
      cast_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= FILL;
      cast_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cast_q <= cast_d;
    end
  end

  assign slot = slot_q;
  assign cast = cast_q;

endmodule

// File: rtl/ballot_collector.sv
// Serial ballot intake that assembles the packed bus for voting.
module ballot_collector
  import voting_pkg::*;
#(
  parameter int          N    = N_DEF,
  parameter int          M    = M_DEF,
  parameter logic [N-1:0] FILL = '0
) (
  input  logic clk,
  input  logic rst,
  ballot_collector_if.slave bus
);

  localparam int S = 2**M;
  localparam logic [M:0] LAST = (M+1)'(S - 1);

  state_e       state_q, state_d;
  logic [M:0]   count_q, count_d;
  logic         dup_err_q, dup_err_d;

  logic [S-1:0] cast;
  logic [N-1:0] slot [S];
  logic         accept;
  logic         hit;
  logic         fresh;
  logic         release_en;

  assign accept     = bus.in_valid & bus.in_ready;
  assign hit        = cast[bus.in_id];
  assign fresh      = accept & ~hit;
  assign release_en = (state_q == DONE) & bus.vote_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      dup_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dup_err_q <= dup_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (bus.close || (fresh && count_q == LAST))
          state_d = DONE;
      end
      DONE: begin
        if (bus.vote_ack)
          state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    dup_err_d = accept & hit;
    if (release_en)
      count_d = '0;
    else if (fresh)
      count_d = count_q + 1'b1;
  end

  always_comb begin
    bus.in_ready   = (state_q == COLLECT) & ~rst;
    bus.vote_valid = (state_q == DONE);
    bus.count      = count_q;
    bus.dup_err    = dup_err_q;
  end

  for (genvar i = 0; i < S; i++) begin : g_slot
    logic wr_i;
    assign wr_i = fresh & (bus.in_id == M'(i));

    ballot_slot #(
      .N    (N),
      .FILL (FILL)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr_i),
      .clr   (release_en),
      .wdata (bus.in_vote),
      .slot  (slot[i]),
      .cast  (cast[i])
    );

    assign bus.vote[slot_lsb(i, N) +: N] = slot[i];
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector.
module tb_ballot_collector;

  localparam int N = 3;
  localparam int M = 5;
  localparam int S = 32;
  localparam logic [N-1:0] FILL = 3'd6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ballot_collector_if #(.N(N), .M(M)) bif ();

  ballot_collector #(
    .N    (N),
    .M    (M),
    .FILL (FILL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [M-1:0] id;
    logic [N-1:0] v;
    logic         cl;
    logic         exp_dup;
  } vec_t;

  typedef struct {
    int           idx;
    logic [N-1:0] val;
  } sb_t;

  sb_t          sbq[$];
  logic [S-1:0] mcast;
  int           mcount;
  logic [N-1:0] exp_slot [S];
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] slot_of(int i);
    logic [(2**M)*N-1:0] b;
    b = bif.vote;
    return b[i*N +: N];
  endfunction

  task automatic model_clear();
    mcast  = '0;
    mcount = 0;
    sbq.delete();
    for (int i = 0; i < S; i++) exp_slot[i] = FILL;
  endtask

  // Drain scoreboard into expected image, then compare every slot
  task automatic check_bus(string name);
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      exp_slot[e.idx] = e.val;
    end
    for (int i = 0; i < S; i++)
      chk($sformatf("%s slot%0d", name, i), slot_of(i), exp_slot[i]);
  endtask

  task automatic ballot(vec_t t, string name);
    bit fresh;
    fresh = !mcast[t.id];
    if (fresh) begin
      sbq.push_back('{idx: int'(t.id), val: t.v});
      mcast[t.id] = 1'b1;
      mcount++;
    end
    bif.in_valid = 1'b1;
    bif.in_id    = t.id;
    bif.in_vote  = t.v;
    bif.close    = t.cl;
    tick();
    bif.in_valid = 1'b0;
    bif.close    = 1'b0;
    chk({name, " dup_err"}, bif.dup_err, t.exp_dup);
    chk({name, " count"}, bif.count, mcount);
  endtask

  task automatic ack();
    bif.vote_ack = 1'b1;
    tick();
    bif.vote_ack = 1'b0;
    model_clear();
    chk("ack in_ready", bif.in_ready, 1);
    chk("ack vote_valid", bif.vote_valid, 0);
    chk("ack count", bif.count, 0);
    check_bus("ack");
  endtask

  function automatic int winner();
    int h [8];
    int best;
    for (int k = 0; k < 8; k++) h[k] = 0;
    for (int i = 0; i < S; i++) h[slot_of(i)]++;
    best = 0;
    for (int k = 1; k < 8; k++)
      if (h[k] > h[best]) best = k;
    return best;
  endfunction

  int   full_votes [S] = '{5,7,5,4,0,7,0,5,3,3,1,2,2,1,4,2,
                          3,5,6,0,5,5,7,1,6,3,5,5,3,1,7,2};
  vec_t vecs [S];
  vec_t dups [3];

  initial begin
    bif.in_valid = 1'b0;
    bif.in_id    = '0;
    bif.in_vote  = '0;
    bif.close    = 1'b0;
    bif.vote_ack = 1'b0;
    rst          = 1'b1;
    model_clear();

    for (int i = 0; i < S; i++)
      vecs[i] = '{id: M'(i), v: N'(full_votes[i]), cl: 1'b0, exp_dup: 1'b0};
    dups[0] = '{id: 5'd4, v: 3'd6, cl: 1'b0, exp_dup: 1'b0};
    dups[1] = '{id: 5'd4, v: 3'd2, cl: 1'b0, exp_dup: 1'b1};
    dups[2] = '{id: 5'd4, v: 3'd1, cl: 1'b0, exp_dup: 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst in_ready", bif.in_ready, 0);
    chk("rst count", bif.count, 0);
    chk("rst vote_valid", bif.vote_valid, 0);
    chk("rst dup_err", bif.dup_err, 0);
    check_bus("rst");
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", bif.in_ready, 1);

    // 1: full election
    for (int i = 0; i < S; i++) begin
      chk("full vv low", bif.vote_valid, 0);
      ballot(vecs[i], $sformatf("full%0d", i));
    end
    chk("full vote_valid", bif.vote_valid, 1);
    chk("full in_ready", bif.in_ready, 0);
    check_bus("full");
    chk("full winner", winner(), 5);
    ack();

    // 2: duplicates, back-to-back pulses
    for (int i = 0; i < 3; i++)
      ballot(dups[i], $sformatf("dup%0d", i));
    tick();
    chk("dup pulse end", bif.dup_err, 0);
    chk("dup slot4", slot_of(4), 6);
    ballot('{id: 5'd9, v: 3'd3, cl: 1'b1, exp_dup: 1'b0}, "dupclose");
    chk("dup vv", bif.vote_valid, 1);
    check_bus("dup");
    ack();

    // 3: early close with a same-cycle ballot
    for (int i = 0; i < 10; i++)
      ballot(vecs[i], $sformatf("early%0d", i));
    chk("early vv low", bif.vote_valid, 0);
    ballot('{id: 5'd10, v: 3'd1, cl: 1'b1, exp_dup: 1'b0}, "close");
    chk("early count", bif.count, 11);
    chk("early vv", bif.vote_valid, 1);
    check_bus("early");

    // 4: hold in DONE, then release
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = 1'b1;
      bif.in_id    = M'(i + 20);
      bif.in_vote  = N'(i);
      bif.close    = 1'b1;
      #1;
      chk("hold in_ready", bif.in_ready, 0);
      tick();
      chk("hold dup_err", bif.dup_err, 0);
      chk("hold count", bif.count, 11);
      chk("hold vv", bif.vote_valid, 1);
    end
    bif.in_valid = 1'b0;
    bif.close    = 1'b0;
    check_bus("hold");
    ack();

    // 5: reset mid-collection
    for (int i = 0; i < 17; i++)
      ballot(vecs[i], $sformatf("mid%0d", i));
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", bif.in_ready, 0);
    tick();
    model_clear();
    chk("mid rst count", bif.count, 0);
    chk("mid rst vv", bif.vote_valid, 0);
    chk("mid rst in_ready2", bif.in_ready, 0);
    check_bus("mid rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      ballot(vecs[i], $sformatf("restart%0d", i));
    check_bus("restart");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
